// File: rtl/id_operand_scoreboard_pkg.sv
// Shared constants and types for the ID operand scoreboard.
// Holds default widths and the stall-reason encoding.
package id_operand_scoreboard_pkg;

    localparam int AW         = 5;
    localparam int PEND_W_DEF = 2;
    localparam int NFWD_DEF   = 2;

    typedef enum logic [2:0] {
        ST_NONE,
        ST_FLUSH,
        ST_HELD,
        ST_RAW,
        ST_PEND,
        ST_FULL
    } stall_e;

endpackage

// File: rtl/id_operand_scoreboard_fwd_mux.sv
// Priority operand select for one source register.
// Order: immediate, x0, forward[lowest index], writeback, register file.
module id_fwd_mux
    import id_operand_scoreboard_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = NFWD_DEF
) (
    input  logic [AW-1:0]        rs,
    input  logic                 use_rs,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      rf,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [AW*NFWD-1:0]   fwd_addr,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 wb_hit,
    output logic [XLEN-1:0]      data
);

    // Later assignments win, so forwards are scanned oldest to youngest
    always_comb begin
        wb_hit = wb_valid && (wb_addr == rs);
        data   = rf;
        if (wb_hit)
            data = wb_data;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*AW +: AW] == rs))
                data = fwd_data[i*XLEN +: XLEN];
        end
        if (rs == '0)
            data = '0;
        if (!use_rs)
            data = imm;
    end

endmodule

// File: rtl/id_operand_scoreboard.sv
// Operand fetch / hazard stage with per-register pending-load counters.
// Optional ID_SB_STATS_EN adds stall_cycles and hazard_cycles counters.
module id_operand_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NFWD   = NFWD_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        in_rs1,
    input  logic [AW-1:0]        in_rs2,
    input  logic [AW-1:0]        in_rd,
    input  logic                 in_use1,
    input  logic                 in_use2,
    input  logic                 in_wr,
    input  logic                 in_long,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [15:0]          in_ctl,
    input  logic [XLEN-1:0]      rf_data1,
    input  logic [XLEN-1:0]      rf_data2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [AW*NFWD-1:0]   fwd_addr,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [AW-1:0]        out_rd,
    output logic                 out_wr,
    output logic                 out_long,
    output logic [15:0]          out_ctl
`ifdef ID_SB_STATS_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          hazard_cycles
`endif
);

    localparam logic [PEND_W-1:0] PMAX = '1;

    logic [PEND_W-1:0] pend [NREG];
    logic [XLEN-1:0]   op1, op2;
    logic              wb_hit1, wb_hit2;
    logic              need1, need2, raw, pnd, full, held;
    logic              in_fire, out_fire, load, inc, dec;
    stall_e            reason;

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_mux1 (
        .rs(in_rs1), .use_rs(in_use1), .imm(in_imm), .rf(rf_data1),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_hit(wb_hit1), .data(op1)
    );

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_mux2 (
        .rs(in_rs2), .use_rs(in_use2), .imm(in_imm), .rf(rf_data2),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_hit(wb_hit2), .data(op2)
    );

    assign need1 = in_use1 && (in_rs1 != '0);
    assign need2 = in_use2 && (in_rs2 != '0);

    assign raw = (need1 && out_valid && out_wr && (out_rd == in_rs1)) ||
                 (need2 && out_valid && out_wr && (out_rd == in_rs2));

    assign pnd = (need1 && ((pend[in_rs1] > PEND_W'(1)) ||
                            ((pend[in_rs1] == PEND_W'(1)) && !wb_hit1))) ||
                 (need2 && ((pend[in_rs2] > PEND_W'(1)) ||
                            ((pend[in_rs2] == PEND_W'(1)) && !wb_hit2)));

    assign full = in_long && in_wr && (pend[in_rd] == PMAX);
    assign held = out_valid && !out_ready;

    // Highest-priority reason the stage cannot accept this cycle
    always_comb begin
        reason = ST_NONE;
        if (flush)     reason = ST_FLUSH;
        else if (held) reason = ST_HELD;
        else if (raw)  reason = ST_RAW;
        else if (pnd)  reason = ST_PEND;
        else if (full) reason = ST_FULL;
    end

    assign in_ready = (reason == ST_NONE);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready && !flush;
    assign load     = !out_valid || out_ready;
    assign inc      = out_fire && out_long && out_wr && (out_rd != '0);
    assign dec      = wb_valid && (wb_addr != '0);

    // Output packet register; flush kills it without touching counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wr    <= 1'b0;
            out_long  <= 1'b0;
            out_ctl   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= in_fire;
            if (in_fire) begin
                out_op1  <= op1;
                out_op2  <= op2;
                out_rd   <= in_rd;
                out_wr   <= in_wr;
                out_long <= in_long;
                out_ctl  <= in_ctl;
            end
        end
    end

    // Pending-load counters: +1 when a load enters EX, -1 on its writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++)
                pend[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc && (out_rd == AW'(r)) &&
                    !(dec && (wb_addr == AW'(r))))
                    pend[r] <= pend[r] + 1'b1;
                else if (dec && (wb_addr == AW'(r)) &&
                         !(inc && (out_rd == AW'(r))) &&
                         (pend[r] != '0))
                    pend[r] <= pend[r] - 1'b1;
            end
        end
    end

    // A writeback must always match an outstanding load
    a_dec_underflow: assert property (
        @(posedge clk) disable iff (!rst)
        (dec && !(inc && (out_rd == wb_addr))) |-> (pend[wb_addr] != '0)
    );

`ifdef ID_SB_STATS_EN
    // Saturating stall and scoreboard-hazard cycle counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles  <= '0;
            hazard_cycles <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (in_valid && (reason == ST_PEND) && (hazard_cycles != '1))
                hazard_cycles <= hazard_cycles + 1'b1;
        end
    end
`endif

endmodule
